// File: rtl/matmul_mac_ctrl.sv
// Dot-product sequencer: reads N sign-magnitude operand pairs and accumulates
// their products in two's complement. Define MAC_SATURATE_EN to clamp on overflow.
module matmul_mac_ctrl #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int AW    = 2,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    a_data,
    input  logic [DW-1:0]    b_data,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);
    localparam int MW = DW - 1;
    localparam int PW = 2 * DW - 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    idx;
    logic             data_valid;
    logic [ACC_W-1:0] acc;

    logic [PW-1:0]    mag;
    logic             neg;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_next;

    // Negative zero is folded to +0 by qualifying the sign with a nonzero magnitude.
    always_comb begin
        mag      = PW'(a_data[MW-1:0]) * PW'(b_data[MW-1:0]);
        neg      = (a_data[DW-1] ^ b_data[DW-1]) && (mag != '0);
        prod_ext = {{(ACC_W-PW){1'b0}}, mag};
        prod     = neg ? (~prod_ext + 1'b1) : prod_ext;
        sum      = acc + prod;
        add_ovf  = (acc[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_SATURATE_EN
        if (add_ovf)
            acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_next = sum;
`else
        acc_next = sum;
`endif
    end

    assign rd_addr = idx;
    assign result  = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            data_valid <= 1'b0;
            acc        <= '0;
            ovf        <= 1'b0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Operand data arrives one cycle after its read strobe.
            data_valid <= rd_en;
            if (data_valid) begin
                acc <= acc_next;
                if (add_ovf)
                    ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        idx   <= '0;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == AW'(N - 1)) begin
                        state <= DRAIN;
                        idx   <= '0;
                        rd_en <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_mac_ctrl.sv
// Directed bench for matmul_mac_ctrl at default parameters (DW=8, N=4, ACC_W=16).
module tb_matmul_mac_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [7:0]  a_data = 8'h7F;
    logic [7:0]  b_data = 8'h7F;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    logic [7:0]  a_mem [4];
    logic [7:0]  b_mem [4];
    int          vectors = 0;
    int          errors  = 0;

    matmul_mac_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .a_data(a_data), .b_data(b_data), .busy(busy), .done(done),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Operand stores: one-cycle read latency, junk outside a read window.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[rd_addr];
            b_data <= b_mem[rd_addr];
        end else begin
            a_data <= 8'h7F;
            b_data <= 8'h7F;
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            a_mem[i] = a[8*i +: 8];
            b_mem[i] = b[8*i +: 8];
        end
    endtask

    // Pulses start and counts edges after the accepting edge until done (-1 on timeout).
    task automatic run_op(output int lat, output logic [15:0] res, output logic o);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        res = result;
        o   = ovf;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        vectors++;
        if ({rd_en, rd_addr, busy, done, result, ovf} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {rd_en, rd_addr, busy, done, result, ovf});
        end
        @(posedge clk); #2 rst = 1'b0;
        $display("reset: outputs %h", {rd_en, rd_addr, busy, done, result, ovf});
    endtask

    task automatic test_basic;
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            logic [3:0] want;
            if (e <= 3)      want = {1'b1, 2'(e), 1'b1};
            else if (e == 4) want = 4'b0001;
            else             want = 4'b0000;
            vectors++;
            if ({rd_en, rd_addr, busy} !== want) begin
                errors++;
                $display("FAIL basic_seq edge%0d got rd_en/addr/busy=%b want=%b", e, {rd_en, rd_addr, busy}, want);
            end
            vectors++;
            if (done !== (e == 5)) begin
                errors++;
                $display("FAIL basic_done edge%0d got=%b want=%b", e, done, (e == 5));
            end
            if (e >= 5) begin
                vectors++;
                if (result !== 16'd70 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_result edge%0d got=%h ovf=%b want=0046 ovf=0", e, result, ovf);
                end
            end
            @(posedge clk); #1;
        end
        $display("basic: result=%0d ovf=%b", $signed(result), ovf);
    endtask

    task automatic test_signed;
        int lat; logic [15:0] res; logic o;
        load({8'h83, 8'h80, 8'h02, 8'h81}, {8'h03, 8'h07, 8'h86, 8'h05});
        run_op(lat, res, o);
        vectors++;
        if (lat !== 5 || res !== 16'hFFE6 || o !== 1'b0) begin
            errors++;
            $display("FAIL signed lat=%0d res=%h ovf=%b want lat=5 res=ffe6 ovf=0", lat, res, o);
        end
        $display("signed: result=%0d ovf=%b", $signed(res), o);
    endtask

    task automatic test_overflow;
        int lat; logic [15:0] res; logic o;
        logic [15:0] want;
`ifdef MAC_SATURATE_EN
        want = 16'h7FFF;
`else
        want = 16'hFC04;
`endif
        load(32'h7F7F7F7F, 32'h7F7F7F7F);
        run_op(lat, res, o);
        vectors++;
        if (lat !== 5 || res !== want || o !== 1'b1) begin
            errors++;
            $display("FAIL overflow lat=%0d res=%h ovf=%b want lat=5 res=%h ovf=1", lat, res, o, want);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (result !== want || ovf !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL overflow_hold res=%h ovf=%b done=%b want res=%h ovf=1 done=0", result, ovf, done, want);
        end
        // A clean run must clear the sticky flag.
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        run_op(lat, res, o);
        vectors++;
        if (res !== 16'd70 || o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear res=%h ovf=%b want 0046 ovf=0", res, o);
        end
        $display("overflow: result=%h ovf=%b", want, 1'b1);
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        int first = -1;
        int second = -1;
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        @(posedge clk); #1;
        start = 1'b1;
        // Edge 0 accepts; done after edges 5 and 12 (DONE->IDLE at 6, re-accept at 7).
        for (int e = 0; e <= 13; e++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (first < 0) first = e; else second = e;
                vectors++;
                if (result !== 16'd70 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result edge%0d got=%h ovf=%b want 0046 ovf=0", e, result, ovf);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (dones !== 2 || first !== 5 || second !== 12) begin
            errors++;
            $display("FAIL b2b_dones count=%0d at=%0d,%0d want 2 at 5,12", dones, first, second);
        end
        $display("back_to_back: %0d done pulses at edges %0d,%0d", dones, first, second);
    endtask

    task automatic test_reset_abort;
        int lat; logic [15:0] res; logic o;
        int seen = 0;
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rd_addr !== 2'd2 || rd_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre rd_en=%b addr=%0d want 1 2", rd_en, rd_addr);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({rd_en, rd_addr, busy, done, result, ovf} !== 22'd0) begin
            errors++;
            $display("FAIL abort_async got=%h want=0", {rd_en, rd_addr, busy, done, result, ovf});
        end
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done active_cycles=%0d want 0", seen);
        end
        run_op(lat, res, o);
        vectors++;
        if (lat !== 5 || res !== 16'd70 || o !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart lat=%0d res=%h ovf=%b want lat=5 0046 ovf=0", lat, res, o);
        end
        $display("reset_abort: restart result=%0d", $signed(res));
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_overflow;
        test_back_to_back;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/matmul_mac_ctrl.md
MATMUL_MAC_CTRL -- requirements
Module: matmul_mac_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: element width, sign-magnitude (MSB = sign, DW-1 magnitude bits).
REQ-002 SHALL have parameter N, default 4: dot-product length, N >= 2.
REQ-003 SHALL have parameter AW, default 2: address width, AW = clog2(N).
REQ-004 SHALL have parameter ACC_W, default 16: two's-complement accumulator width, ACC_W >= 2*DW-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request one dot product.
REQ-008 rd_en  output  1  operand read strobe to row-A / column-B stores.
REQ-009 rd_addr  output  AW  element index 0..N-1.
REQ-010 a_data  input  DW  row-A element, valid the cycle after its rd_en cycle.
REQ-011 b_data  input  DW  column-B element, same timing as a_data.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  ACC_W  two's-complement dot product.
REQ-015 ovf  output  1  sticky signed-overflow flag for the current dot product.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 at an edge SHALL clear accumulator and ovf, set idx=0, go to RUN.
REQ-018 RUN: rd_en=1, rd_addr=idx; each edge idx++; at the edge with idx=N-1 SHALL go to DRAIN.
REQ-019 DRAIN: rd_en=0; the next edge SHALL go to DONE.
REQ-020 DONE: done=1 for exactly one cycle; next edge SHALL go to IDLE.
REQ-021 Per element: a_data/b_data SHALL be sampled at the edge ending the cycle after the matching rd_en cycle, and accumulated at that edge (edges 2..N+1 after start acceptance, counting the accepting edge as edge 0).
REQ-022 Product magnitude SHALL be the (2*DW-2)-bit product of the magnitude fields; sign = XOR of sign bits.
REQ-023 Zero-magnitude product SHALL contribute 0 regardless of sign (negative zero = 0).
REQ-024 Signed product SHALL be converted to two's complement, sign-extended to ACC_W bits and added to the accumulator.
REQ-025 Signed overflow on any add SHALL set ovf, which SHALL hold until the next accepted start.
REQ-026 done SHALL assert in the cycle after edge N+1; result and ovf SHALL be final then and held until the next accepted start.
REQ-027 start SHALL be ignored in RUN, DRAIN and DONE, with no effect on state, idx or the accumulator.
REQ-028 rd_addr SHALL be 0 whenever rd_en=0.

Reset
REQ-029 rst=1 SHALL force, without waiting for clk: IDLE, idx=0, accumulator=0, and rd_en, rd_addr, busy, done, result, ovf all 0.
REQ-030 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL follow; the next start SHALL begin cleanly.

Configuration
REQ-031 Macro MAC_SATURATE_EN SHALL be the only compile-time option.
REQ-032 With MAC_SATURATE_EN defined, an overflowing add SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf.
REQ-033 Saturation SHALL persist; later adds SHALL continue from the clamped value.
REQ-034 Without MAC_SATURATE_EN, adds SHALL wrap modulo 2^ACC_W and still set ovf.

Verification (defaults DW=8, N=4, ACC_W=16)
REQ-035 Scenario: A=[1,2,3,4], B=[5,6,7,8]; start pulse -> rd_addr 0,1,2,3 on consecutive cycles, done 6 cycles after the start edge, result=70, ovf=0.
REQ-036 Scenario: A=[0x81,0x02,0x80,0x83], B=[0x05,0x86,0x07,0x03] -> result=-5-12+0-9=-26 (0xFFE6), ovf=0.
REQ-037 Scenario: all elements 0x7F, default build -> ovf=1, result=0xFC04 (-1020).
REQ-038 Scenario: all elements 0x7F, MAC_SATURATE_EN build -> ovf=1, result=0x7FFF.
REQ-039 Scenario: start held high throughout -> start ignored while busy and in DONE; back-to-back runs each produce one done and the correct result.
REQ-040 Scenario: rst pulsed while idx=2 -> all outputs 0 immediately, no done pulse; next start yields 70 for REQ-035 data.
